// File: rtl/dr_load_sequencer.sv
// Byte-serial LOAD sequencer: reads a byte, halfword or word from byte-wide memory, highest address
// first, and steers the Data Register strobes so the register ends up holding the extended operand.
module dr_load_sequencer #(
  parameter int ADDR_WIDTH   = 16,
  parameter int MAX_WAIT     = 15,
  parameter bit STRICT_ALIGN = 1'b1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [1:0]            Size,
  input  logic [ADDR_WIDTH-1:0] BaseAddr,
  input  logic                  MemReady,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic                  MemRead,
  output logic [1:0]            DR_FunSel,
  output logic                  DR_E,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE_S = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b10;
  localparam logic [1:0] SZ_WORD   = 2'b11;

  localparam logic [1:0] FS_SEXT  = 2'b00;
  localparam logic [1:0] FS_ZEXT  = 2'b01;
  localparam logic [1:0] FS_SHIFT = 2'b10;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [2:0]            remaining_q, remaining_d;
  logic [7:0]            wait_q, wait_d;
  logic [1:0]            size_q, size_d;
  logic                  first_q, first_d;
  logic                  error_q, error_d;

  logic [2:0]            n_bytes;
  logic                  misaligned;

  always_comb begin
    case (Size)
      SZ_HALF: n_bytes = 3'd2;
      SZ_WORD: n_bytes = 3'd4;
      default: n_bytes = 3'd1;
    endcase
    misaligned = STRICT_ALIGN &&
                 (((Size == SZ_HALF) && BaseAddr[0]) ||
                  ((Size == SZ_WORD) && (BaseAddr[1:0] != 2'b00)));
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    wait_d      = wait_q;
    size_d      = size_q;
    first_d     = first_q;
    error_d     = error_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          size_d  = Size;
          error_d = misaligned;
          if (misaligned) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_FETCH;
            ptr_d       = BaseAddr + ADDR_WIDTH'(n_bytes - 3'd1);
            remaining_d = n_bytes;
            wait_d      = 8'd0;
            first_d     = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (MemReady) begin
          ptr_d       = ptr_q - ADDR_WIDTH'(1);
          remaining_d = remaining_q - 3'd1;
          wait_d      = 8'd0;
          first_d     = 1'b0;
          if (remaining_q == 3'd1) state_d = S_DONE;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_d == WAIT_LIMIT) begin
            state_d = S_DONE;
            error_d = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Everything except DR_E comes from registered state; DR_E follows MemReady in the same cycle.
  always_comb begin
    MemAddr   = '0;
    MemRead   = 1'b0;
    DR_FunSel = FS_SEXT;
    DR_E      = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    Error     = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemAddr = ptr_q;
        MemRead = 1'b1;
        Busy    = 1'b1;
        DR_E    = MemReady;
        if (first_q) DR_FunSel = (size_q == SZ_BYTE_S) ? FS_SEXT : FS_ZEXT;
        else         DR_FunSel = FS_SHIFT;
      end
      S_DONE: begin
        Done  = 1'b1;
        Error = error_q;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      remaining_q <= 3'd0;
      wait_q      <= 8'd0;
      size_q      <= 2'b00;
      first_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      wait_q      <= wait_d;
      size_q      <= size_d;
      first_q     <= first_d;
      error_q     <= error_d;
    end
  end

endmodule
